// File: rtl/clkdiv_pkg.sv
// Shared state encodings and default divisor for the programmable tick-generator controller.
package clkdiv_pkg;
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;

    localparam int CLKDIV_DEFAULT_DIV = 3;
endpackage

// File: rtl/clkdiv_if.sv
// Divisor/burst configuration handshake between a host and the tick-generator controller.
interface clkdiv_if #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_div;
    logic [BURST_W-1:0] cfg_burst;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_burst,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_burst,
        output cfg_ready
    );
endinterface

// File: rtl/div_phase_counter.sv
// Phase counter for the divider: counts 0..div-1 while enabled, flags the last phase of a period.
module div_phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] p,
    output logic             last
);
    logic [CNT_W-1:0] p_reg;

    assign p    = p_reg;
    assign last = (p_reg == div - 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_reg <= '0;
        end else if (clr) begin
            p_reg <= '0;
        end else if (en) begin
            p_reg <= last ? '0 : p_reg + 1'b1;
        end
    end
endmodule

// File: rtl/clkdiv_ctrl.sv
// Programmable divide-by-N tick controller: run/stop FSM, shadowed reconfiguration, burst counting.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int BURST_W     = 8,
    parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
    input  logic    clk,
    input  logic    reset,
    clkdiv_if.slave cfg,
    input  logic    start,
    input  logic    stop,
    output logic    tick,
    output logic    busy,
    output logic    done,
    output logic    div_err
);
    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [CNT_W-1:0]   div_reg;
    logic [BURST_W-1:0] burst_reg;
    logic [BURST_W-1:0] count_reg;
    logic               shadow_full_reg;
    logic [CNT_W-1:0]   shadow_div_reg;
    logic [BURST_W-1:0] shadow_burst_reg;
    logic               done_reg;
    logic               div_err_reg;
    logic [CNT_W-1:0]   p;
    logic               last;
    logic               xfer;
    logic               cfg_ok;
    logic               is_tick;
    logic               burst_hit;
    logic               run_end;
    logic               apply;

    div_phase_counter #(
        .CNT_W(CNT_W)
    ) u_phase (
        .clk  (clk),
        .reset(reset),
        .en   (state_reg != ST_IDLE),
        .clr  (state_reg == ST_IDLE),
        .div  (div_reg),
        .p    (p),
        .last (last)
    );

    assign xfer      = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg_ok    = (cfg.cfg_div != '0);
    assign is_tick   = (state_reg == ST_RUN) && (p == '0);
    assign burst_hit = (burst_reg != '0) && (count_reg == burst_reg - 1'b1);
    assign run_end   = stop || (is_tick && burst_hit);
    // A shadow left over when a run ends is taken up on the first idle cycle.
    assign apply     = shadow_full_reg && (last || (state_reg == ST_IDLE));

    assign cfg.cfg_ready = !shadow_full_reg;
    assign tick          = is_tick;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = done_reg;
    assign div_err       = div_err_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (run_end) state_next = last ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (last) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            done_reg    <= 1'b0;
            div_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            done_reg    <= (state_reg != ST_IDLE) && (state_next == ST_IDLE);
            div_err_reg <= xfer && !cfg_ok;
        end
    end

    // Active config changes only while idle or at a period boundary, so no runt periods.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg          <= CNT_W'(DEFAULT_DIV);
            burst_reg        <= '0;
            shadow_full_reg  <= 1'b0;
            shadow_div_reg   <= '0;
            shadow_burst_reg <= '0;
        end else begin
            if (xfer && cfg_ok && (state_reg == ST_IDLE)) begin
                div_reg   <= cfg.cfg_div;
                burst_reg <= cfg.cfg_burst;
            end else if (apply) begin
                div_reg   <= shadow_div_reg;
                burst_reg <= shadow_burst_reg;
            end

            if (xfer && cfg_ok && (state_reg != ST_IDLE)) begin
                shadow_full_reg  <= 1'b1;
                shadow_div_reg   <= cfg.cfg_div;
                shadow_burst_reg <= cfg.cfg_burst;
            end else if (apply) begin
                shadow_full_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if ((state_reg == ST_IDLE) || apply) begin
            count_reg <= '0;
        end else if (is_tick && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Scoreboard bench for clkdiv_ctrl: expected tick/done/div_err events come from period arithmetic.
module tb_clkdiv_ctrl;
    localparam int CNT_W   = 8;
    localparam int BURST_W = 8;
    localparam int K_TICK  = 0;
    localparam int K_DONE  = 1;
    localparam int K_DERR  = 2;
    localparam int NEVER   = 1 << 30;

    typedef struct packed {
        int kind;
        int c;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic stop;
    logic tick;
    logic busy;
    logic done;
    logic div_err;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    clkdiv_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) cfg_bus ();

    clkdiv_ctrl #(
        .CNT_W      (CNT_W),
        .BURST_W    (BURST_W),
        .DEFAULT_DIV(3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cfg    (cfg_bus),
        .start  (start),
        .stop   (stop),
        .tick   (tick),
        .busy   (busy),
        .done   (done),
        .div_err(div_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int b2i(input logic x);
        return (x === 1'b1) ? 1 : 0;
    endfunction

    function automatic string kname(input int k);
        if (k == K_TICK) return "tick";
        if (k == K_DONE) return "done";
        return "div_err";
    endfunction

    // Events at or after lim are suppressed: a reset wipes out whatever was still pending.
    function automatic void add(input int kind, input int c, input int lim);
        exp_t e;
        if (c >= lim) return;
        e.kind = kind;
        e.c    = c;
        for (int i = 0; i < expq.size(); i++) begin
            if (expq[i].c > c || (expq[i].c == c && expq[i].kind > kind)) begin
                expq.insert(i, e);
                return;
            end
        end
        expq.push_back(e);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d want %0d", name, cyc, act, req);
        end
    endtask

    task automatic mon_one(input int kind, input logic v);
        if (v === 1'b1) begin
            checks++;
            if (expq.size() > 0 && expq[0].kind == kind && expq[0].c == cyc) begin
                void'(expq.pop_front());
            end else begin
                errors++;
                if (expq.size() > 0)
                    $display("FAIL %s cycle %0d: got pulse, want next %s at %0d",
                             kname(kind), cyc, kname(expq[0].kind), expq[0].c);
                else
                    $display("FAIL %s cycle %0d: got pulse, want none", kname(kind), cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].c < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s missing: got none by cycle %0d, want at %0d",
                     kname(expq[0].kind), cyc, expq[0].c);
            void'(expq.pop_front());
        end
        mon_one(K_TICK, tick);
        mon_one(K_DONE, done);
        mon_one(K_DERR, div_err);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One run: optional config load in idle, start, then stop / mid-run cfg / reset at offsets from k.
    // n2 == 0 with cfg_off >= 0 sends an illegal divisor; n2 != 0 is a shadowed reconfiguration.
    task automatic run_case(input bit load, input int n1, input int b1, input int stop_off,
                            input int cfg_off, input int n2, input int b2, input int rst_off,
                            input bit both);
        int k, d, t, e, r, endc, re, j, c, co;
        bit reconf;
        reconf = (cfg_off >= 0) && (n2 != 0);
        co = cfg_off;
        r  = NEVER;
        t  = NEVER;
        e  = NEVER;
        step();
        if (load) begin
            chk("idle_cfg_ready", b2i(cfg_bus.cfg_ready), 1);
            cfg_bus.cfg_valid = 1'b1;
            cfg_bus.cfg_div   = CNT_W'(n1);
            cfg_bus.cfg_burst = BURST_W'(b1);
            step();
            cfg_bus.cfg_valid = 1'b0;
        end
        start = 1'b1;
        stop  = both;
        k = cyc + 1;
        if (rst_off >= 0) r = k + rst_off;

        if (reconf) begin
            t = k + co;
            e = k + (co / n1 + 1) * n1 - 1;
            if (e == t) e += n1;
            for (int i = 0; k + i * n1 <= e; i++) add(K_TICK, k + i * n1, r);
            for (int i = 0; i < b2; i++) add(K_TICK, e + 1 + i * n2, r);
            d = e + 1 + b2 * n2;
        end else begin
            re = NEVER;
            if (b1 > 0) re = k + (b1 - 1) * n1;
            if (stop_off >= 0 && k + stop_off < re) re = k + stop_off;
            j = (re - k) / n1;
            for (int i = 0; i <= j; i++) add(K_TICK, k + i * n1, r);
            d = k + (j + 1) * n1;
            if (co >= 0) begin
                if (co > d - k) co = d - k;
                add(K_DERR, k + co + 1, r);
            end
        end
        add(K_DONE, d, r);
        endc = (rst_off >= 0) ? r + 3 : d + 2;
        $display("run N=%0d B=%0d start=%0d stop_off=%0d cfg_off=%0d N2=%0d B2=%0d end=%0d%s",
                 n1, b1, k, stop_off, co, n2, b2, (rst_off >= 0) ? r : d,
                 (rst_off >= 0) ? " (reset)" : "");

        c = k - 1;
        while (c < endc) begin
            step();
            c = cyc;
            start = 1'b0;
            stop  = 1'b0;
            reset = 1'b0;
            cfg_bus.cfg_valid = 1'b0;
            if (c == k) chk("busy_first_run", b2i(busy), 1);
            if (c < r) begin
                if (reconf && c == t + 1) chk("cfg_ready_shadow_full", b2i(cfg_bus.cfg_ready), 0);
                if (reconf && c == e + 1) chk("cfg_ready_after_apply", b2i(cfg_bus.cfg_ready), 1);
                if (rst_off < 0 && c == d - 1) chk("busy_before_end", b2i(busy), 1);
                if (rst_off < 0 && c == d) chk("busy_at_done", b2i(busy), 0);
                if (stop_off >= 0 && c == k + stop_off) stop = 1'b1;
                if (co >= 0 && c == k + co) begin
                    cfg_bus.cfg_valid = 1'b1;
                    cfg_bus.cfg_div   = CNT_W'(n2);
                    cfg_bus.cfg_burst = BURST_W'(b2);
                end
                if (c == k + 1 && c < d) start = 1'b1;
            end
            if (c == r) begin
                reset = 1'b1;
                #1;
                chk("busy_on_reset", b2i(busy), 0);
                chk("tick_on_reset", b2i(tick), 0);
                chk("cfg_ready_on_reset", b2i(cfg_bus.cfg_ready), 1);
            end
        end
        @(negedge clk);
        #1;
        chk("queue_drained", expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by time %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_div   = '0;
        cfg_bus.cfg_burst = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reset_tick", b2i(tick), 0);
            chk("reset_busy", b2i(busy), 0);
            chk("reset_done", b2i(done), 0);
            chk("reset_div_err", b2i(div_err), 0);
            chk("reset_cfg_ready", b2i(cfg_bus.cfg_ready), 1);
            start = 1'b1;
            cfg_bus.cfg_valid = 1'b1;
        end
        start = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_case(1'b0, 3, 0, 4, -1, 0, 0, -1, 1'b0);     // default divisor, stop mid-period
        run_case(1'b1, 5, 4, -1, -1, 0, 0, -1, 1'b0);    // burst of 4 then drain
        run_case(1'b1, 3, 0, -1, 1, 4, 2, -1, 1'b0);     // shadowed change to N=4
        run_case(1'b1, 3, 0, 8, 2, 0, 7, -1, 1'b1);      // illegal divisor, start+stop together
        run_case(1'b1, 5, 2, -1, -1, 0, 0, 7, 1'b0);     // reset mid-drain
        run_case(1'b1, 1, 3, -1, -1, 0, 0, -1, 1'b0);    // N=1 back-to-back ticks
        run_case(1'b1, 255, 2, -1, -1, 0, 0, -1, 1'b0);  // largest divisor

        for (int it = 0; it < 20; it++) begin
            int n, b, so, co, bb;
            bit both;
            n  = int'($urandom_range(1, 7));
            b  = int'($urandom_range(0, 4));
            if (b == 0) so = int'($urandom_range(0, 3 * n));
            else so = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, b * n + 1)) : -1;
            co = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2 * n)) : -1;
            bb = int'($urandom_range(0, 255));
            both = ($urandom_range(0, 3) == 0);
            run_case(1'b1, n, b, so, co, 0, bb, -1, both);
        end

        for (int it = 0; it < 8; it++) begin
            int n, co, n2, b2;
            n  = int'($urandom_range(1, 6));
            co = int'($urandom_range(0, 2 * n));
            n2 = int'($urandom_range(1, 6));
            b2 = int'($urandom_range(1, 3));
            run_case(1'b1, n, 0, -1, co, n2, b2, -1, 1'b0);
        end

        for (int it = 0; it < 4; it++) begin
            int n, b, ro;
            n  = int'($urandom_range(2, 6));
            b  = int'($urandom_range(1, 3));
            ro = int'($urandom_range(0, b * n - 1));
            run_case(1'b1, n, b, -1, -1, 0, 0, ro, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
